memshare_regfile_loader: RTL and testbench

Writer-side front end of the memShare L1PA register file: accepts a valid/ready stream of Type-0 page words from the host/configuration path and issues `regType0_waddr/wdata/we` writes into the regFile. Loads run at one page per cycle from a programmable base page with wrap-around. Writes are interlocked against `scu_memShare_busy_i`, so no page is modified while an SCU.memShare() pipeline cycle reads the shift-pattern sequences. Loads report completion and framing errors.

---
 rtl/memShare_config_pkg.sv | 15 +
 rtl/memshare_ldr_wr_stage.sv | 59 +++++
 rtl/memshare_regfile_loader.sv | 146 ++++++++++++++
 tb/tb_memshare_regfile_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memShare_config_pkg.sv
// Shared memShare configuration constants and the regFile loader state encoding.
package memShare_config_pkg;

  localparam int L1PA_REGFILE_PAGE_NUM   = 64;
  localparam int L1PA_REGFILE_ADDR_WIDTH = $clog2(L1PA_REGFILE_PAGE_NUM);
  localparam int L1PA_REGFILE_PAGE_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } memshare_ldr_state_e;

endpackage

// File: rtl/memshare_ldr_wr_stage.sv
// Single-entry write buffer in front of the Type-0 regFile write port.
// The strobe is held off while an SCU.memShare() cycle is reading the pages.
module memshare_ldr_wr_stage
  import memShare_config_pkg::*;
#(
  parameter int ADDR_WIDTH = L1PA_REGFILE_ADDR_WIDTH,
  parameter int PAGE_WIDTH = L1PA_REGFILE_PAGE_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [PAGE_WIDTH-1:0] data_i,
  input  logic                  busy_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [PAGE_WIDTH-1:0] wdata_o,
  output logic                  pend_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PAGE_WIDTH-1:0] data_q, data_d;
  logic                  pend_q, pend_d;
  logic                  we;

  assign we = pend_q & ~busy_i;

  // A new beat wins over the clearing strobe so back-to-back writes never drop one.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    pend_d = pend_q;
    if (load_i) begin
      addr_d = addr_i;
      data_d = data_i;
      pend_d = 1'b1;
    end else if (we) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign we_o    = we;
  assign waddr_o = addr_q;
  assign wdata_o = data_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/memshare_regfile_loader.sv
// Writer-side front end of the memShare L1PA register file: streams Type-0 page
// words into the regFile from a base page, interlocked against SCU.memShare().
module memshare_regfile_loader
  import memShare_config_pkg::*;
#(
  parameter int PAGE_NUM   = L1PA_REGFILE_PAGE_NUM,
  parameter int ADDR_WIDTH = L1PA_REGFILE_ADDR_WIDTH,
  parameter int PAGE_WIDTH = L1PA_REGFILE_PAGE_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] load_base_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic [PAGE_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_valid_i,
  input  logic                  cfg_last_i,
  output logic                  cfg_ready_o,
  input  logic                  scu_memShare_busy_i,
  output logic [ADDR_WIDTH-1:0] regType0_waddr_o,
  output logic [PAGE_WIDTH-1:0] regType0_wdata_o,
  output logic                  regType0_we_o,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic [ADDR_WIDTH:0]   pages_written_o
);

  localparam logic [ADDR_WIDTH:0] PagesMax = (ADDR_WIDTH+1)'(PAGE_NUM);

  memshare_ldr_state_e   state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   acc_q, acc_d;
  logic [ADDR_WIDTH:0]   pw_q, pw_d;
  logic                  err_q, err_d;

  logic                  ready;
  logic                  accept;
  logic                  we;
  logic                  pend;
  logic [ADDR_WIDTH:0]   accNext;
  logic [ADDR_WIDTH-1:0] beatAddr;

  assign ready    = (state_q == LOAD) & ~scu_memShare_busy_i & (acc_q < len_q);
  assign accept   = ready & cfg_valid_i;
  assign accNext  = acc_q + 1'b1;
  assign beatAddr = base_q + acc_q[ADDR_WIDTH-1:0];

  memshare_ldr_wr_stage #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PAGE_WIDTH(PAGE_WIDTH)
  ) u_wr_stage (
    .sys_clk (sys_clk),
    .rst     (rst),
    .load_i  (accept),
    .addr_i  (beatAddr),
    .data_i  (cfg_data_i),
    .busy_i  (scu_memShare_busy_i),
    .we_o    (we),
    .waddr_o (regType0_waddr_o),
    .wdata_o (regType0_wdata_o),
    .pend_o  (pend)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    acc_d   = acc_q;
    err_d   = err_q;
    pw_d    = pw_q;
    if (we && pw_q != PagesMax) begin
      pw_d = pw_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          base_d = load_base_i;
          len_d  = load_len_i;
          acc_d  = '0;
          pw_d   = '0;
          if (load_len_i == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // The final expected beat must carry last; an early last truncates the load.
        if (accept) begin
          acc_d = accNext;
          if (accNext == len_q) begin
            if (!cfg_last_i) begin
              err_d = 1'b1;
            end
            state_d = DRAIN;
          end else if (cfg_last_i) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!pend) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      pw_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      pw_q    <= pw_d;
    end
  end

  assign cfg_ready_o     = ready;
  assign regType0_we_o   = we;
  assign load_busy_o     = (state_q != IDLE);
  assign load_done_o     = (state_q == DONE);
  assign load_err_o      = err_q;
  assign pages_written_o = pw_q;

endmodule

// File: tb/tb_memshare_regfile_loader.sv
// Directed bench for memshare_regfile_loader: a negedge monitor logs every
// regFile write and done pulse, and each scenario compares the log to hand values.
module tb_memshare_regfile_loader;

  localparam int AW = 6;
  localparam int PW = 7;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start_i = 1'b0;
  logic [AW-1:0] load_base_i = '0;
  logic [AW:0]   load_len_i = '0;
  logic [PW-1:0] cfg_data_i = '0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_last_i = 1'b0;
  logic          cfg_ready_o;
  logic          scu_memShare_busy_i = 1'b0;
  logic [AW-1:0] regType0_waddr_o;
  logic [PW-1:0] regType0_wdata_o;
  logic          regType0_we_o;
  logic          load_busy_o;
  logic          load_done_o;
  logic          load_err_o;
  logic [AW:0]   pages_written_o;

  memshare_regfile_loader dut (
    .sys_clk             (sys_clk),
    .rst                 (rst),
    .load_start_i        (load_start_i),
    .load_base_i         (load_base_i),
    .load_len_i          (load_len_i),
    .cfg_data_i          (cfg_data_i),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_last_i          (cfg_last_i),
    .cfg_ready_o         (cfg_ready_o),
    .scu_memShare_busy_i (scu_memShare_busy_i),
    .regType0_waddr_o    (regType0_waddr_o),
    .regType0_wdata_o    (regType0_wdata_o),
    .regType0_we_o       (regType0_we_o),
    .load_busy_o         (load_busy_o),
    .load_done_o         (load_done_o),
    .load_err_o          (load_err_o),
    .pages_written_o     (pages_written_o)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [AW-1:0] wAddrQ[$];
  logic [PW-1:0] wDataQ[$];
  int wCycQ[$];
  int doneCount = 0;
  int doneCyc = 0;
  int weBusyCount = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (regType0_we_o) begin
      wAddrQ.push_back(regType0_waddr_o);
      wDataQ.push_back(regType0_wdata_o);
      wCycQ.push_back(cyc);
      if (scu_memShare_busy_i) weBusyCount++;
    end
    if (load_done_o) begin
      doneCount++;
      doneCyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearLog();
    wAddrQ.delete();
    wDataQ.delete();
    wCycQ.delete();
    doneCount = 0;
    weBusyCount = 0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len);
    load_base_i  = base;
    load_len_i   = len;
    load_start_i = 1'b1;
    @(posedge sys_clk); #1;
    load_start_i = 1'b0;
  endtask

  task automatic sendBeats(input int n, input int lastAt, input logic [PW-1:0] d0);
    for (int i = 0; i < n; i++) begin
      int t;
      logic acc;
      t = 0;
      acc = 1'b0;
      cfg_valid_i = 1'b1;
      cfg_data_i  = d0 + PW'(i);
      cfg_last_i  = (i + 1 == lastAt);
      while (!acc && t < 30) begin
        @(negedge sys_clk);
        acc = cfg_ready_o;
        @(posedge sys_clk); #1;
        t++;
      end
      if (!acc) begin
        checkOutput("beatTimeout", 0, 1);
        break;
      end
    end
    cfg_valid_i = 1'b0;
    cfg_last_i  = 1'b0;
  endtask

  task automatic waitDone();
    int t;
    t = 0;
    while (doneCount == 0 && t < 40) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (doneCount == 0) checkOutput("doneTimeout", 0, 1);
    @(posedge sys_clk); #1;
  endtask

  task automatic checkWrites(input string tag, input int n, input logic [AW-1:0] base, input logic [PW-1:0] d0);
    checkOutput({tag, ".count"}, wAddrQ.size(), n);
    for (int i = 0; i < n && i < wAddrQ.size(); i++) begin
      logic [AW-1:0] a;
      logic [PW-1:0] d;
      a = base + AW'(i);
      d = d0 + PW'(i);
      checkOutput($sformatf("%s.addr%0d", tag, i), wAddrQ[i], a);
      checkOutput($sformatf("%s.data%0d", tag, i), wDataQ[i], d);
    end
    checkOutput({tag, ".weWhileBusy"}, weBusyCount, 0);
  endtask

  task automatic checkResetState(input string tag);
    @(negedge sys_clk);
    checkOutput({tag, ".ready"}, cfg_ready_o, 0);
    checkOutput({tag, ".we"}, regType0_we_o, 0);
    checkOutput({tag, ".waddr"}, regType0_waddr_o, 0);
    checkOutput({tag, ".wdata"}, regType0_wdata_o, 0);
    checkOutput({tag, ".busy"}, load_busy_o, 0);
    checkOutput({tag, ".done"}, load_done_o, 0);
    checkOutput({tag, ".err"}, load_err_o, 0);
    checkOutput({tag, ".pw"}, pages_written_o, 0);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Basic contiguous load of pages 0..3.
    clearLog();
    applyStimulus(6'd0, 7'd4);
    @(negedge sys_clk);
    checkOutput("basic.startToReady", cfg_ready_o, 1);
    @(posedge sys_clk); #1;
    sendBeats(4, 4, 7'h10);
    waitDone();
    checkWrites("basic", 4, 6'd0, 7'h10);
    if (wCycQ.size() == 4) begin
      checkOutput("basic.consecutive", wCycQ[3] - wCycQ[0], 3);
      checkOutput("basic.doneLatency", doneCyc - wCycQ[3], 2);
    end
    checkOutput("basic.doneCount", doneCount, 1);
    checkOutput("basic.err", load_err_o, 0);
    checkOutput("basic.pw", pages_written_o, 4);
    checkOutput("basic.idle", load_busy_o, 0);

    // Early last on beat 2 of 4.
    clearLog();
    applyStimulus(6'd20, 7'd4);
    sendBeats(2, 2, 7'h30);
    waitDone();
    checkWrites("early", 2, 6'd20, 7'h30);
    checkOutput("early.doneCount", doneCount, 1);
    checkOutput("early.err", load_err_o, 1);
    checkOutput("early.pw", pages_written_o, 2);

    // Wrap-around from page 62; also clears the sticky error.
    clearLog();
    applyStimulus(6'd62, 7'd4);
    sendBeats(4, 4, 7'h40);
    waitDone();
    checkWrites("wrap", 4, 6'd62, 7'h40);
    if (wAddrQ.size() == 4) begin
      checkOutput("wrap.page2", wAddrQ[2], 0);
      checkOutput("wrap.page3", wAddrQ[3], 1);
    end
    checkOutput("wrap.err", load_err_o, 0);
    checkOutput("wrap.pw", pages_written_o, 4);

    // Busy for 3 cycles right after beat 2 is accepted.
    clearLog();
    applyStimulus(6'd8, 7'd4);
    sendBeats(2, 0, 7'h50);
    scu_memShare_busy_i = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_data_i  = 7'h52;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      checkOutput($sformatf("busy.ready%0d", k), cfg_ready_o, 0);
      checkOutput($sformatf("busy.we%0d", k), regType0_we_o, 0);
      @(posedge sys_clk); #1;
    end
    scu_memShare_busy_i = 1'b0;
    cfg_valid_i = 1'b0;
    @(negedge sys_clk);
    checkOutput("busy.release.we", regType0_we_o, 1);
    checkOutput("busy.release.addr", regType0_waddr_o, 9);
    @(posedge sys_clk); #1;
    sendBeats(2, 2, 7'h52);
    waitDone();
    checkWrites("busy", 4, 6'd8, 7'h50);
    checkOutput("busy.err", load_err_o, 0);
    checkOutput("busy.pw", pages_written_o, 4);

    // Zero-length load.
    clearLog();
    applyStimulus(6'd5, 7'd0);
    waitDone();
    checkOutput("len0.count", wAddrQ.size(), 0);
    checkOutput("len0.doneCount", doneCount, 1);
    checkOutput("len0.err", load_err_o, 1);
    checkOutput("len0.pw", pages_written_o, 0);

    // Final beat without last: error, but the page is still written.
    clearLog();
    applyStimulus(6'd30, 7'd2);
    sendBeats(2, 0, 7'h60);
    waitDone();
    checkWrites("nolast", 2, 6'd30, 7'h60);
    checkOutput("nolast.err", load_err_o, 1);
    checkOutput("nolast.pw", pages_written_o, 2);

    // Reset while busy holds the pending page-41 write.
    clearLog();
    applyStimulus(6'd40, 7'd6);
    sendBeats(2, 0, 7'h70);
    scu_memShare_busy_i = 1'b1;
    @(posedge sys_clk); #1;
    rst = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    scu_memShare_busy_i = 1'b0;
    checkResetState("midReset");
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("midReset.count", wAddrQ.size(), 1);
    clearLog();
    applyStimulus(6'd50, 7'd2);
    sendBeats(2, 2, 7'h05);
    waitDone();
    checkWrites("afterReset", 2, 6'd50, 7'h05);
    checkOutput("afterReset.err", load_err_o, 0);

    // A start mid-load must not disturb the captured base and length.
    clearLog();
    applyStimulus(6'd10, 7'd3);
    sendBeats(1, 0, 7'h20);
    applyStimulus(6'd0, 7'd1);
    sendBeats(2, 2, 7'h21);
    waitDone();
    checkWrites("startIgnored", 3, 6'd10, 7'h20);
    checkOutput("startIgnored.doneCount", doneCount, 1);
    checkOutput("startIgnored.err", load_err_o, 0);
    checkOutput("startIgnored.pw", pages_written_o, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
